// File: rtl/des_frame_pkg.sv
// Shared types and constants for the deserializer-side framer.
package des_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PAYLOAD,
        ST_CHECK,
        ST_SYNC_WAIT
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
    localparam int         MAX_PAYLOAD_LEN = 16;
    localparam int         STATS_W         = 16;

    function automatic logic [STATS_W-1:0] stat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/des_frame_buf.sv
// Two-bank payload buffer: one bank fills from the framer while the other
// is replayed as a gap-free burst with start/end markers.
module des_frame_buf
    import des_frame_pkg::*;
#(
    parameter int PAYLOAD_LEN = 4,
    localparam int IDX_W = $clog2(PAYLOAD_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof
);

    logic [7:0]       mem [2][PAYLOAD_LEN];
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < PAYLOAD_LEN; i++)
                    mem[b][i] <= '0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if (wr_en)
                mem[wr_bank][wr_idx] <= wr_data;

            // Beat 0 goes out on the commit edge so it lines up with frame_ok.
            if (commit) begin
                rd_bank   <= wr_bank;
                rd_idx    <= IDX_W'(1);
                out_data  <= mem[wr_bank][0];
                out_valid <= 1'b1;
                out_sof   <= 1'b1;
                out_eof   <= 1'b0;
            end else if (out_valid && !out_eof) begin
                out_data <= mem[rd_bank][rd_idx];
                out_sof  <= 1'b0;
                out_eof  <= (rd_idx == IDX_W'(PAYLOAD_LEN - 1));
                rd_idx   <= rd_idx + 1'b1;
            end else begin
                out_data  <= '0;
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/des_frame_sync.sv
// Receive framer: sync hunt, XOR checksum, frame lock, ping-pong payload emit.
// Optional DES_FRAME_STATS_EN adds saturating good/bad frame counters.
//
// state     | meaning
// HUNT      | discarding bytes until a sync byte
// PAYLOAD   | storing payload bytes and accumulating XOR
// CHECK     | next byte is the checksum
// SYNC_WAIT | after a frame, the next byte must be a sync byte
module des_frame_sync
    import des_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int         PAYLOAD_LEN = 4,
    parameter int         LOCK_GOOD   = 2,
    parameter int         LOSS_BAD    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic [7:0]         out_data,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eof,
    output logic               frame_ok,
    output logic               frame_err,
    output logic               locked
`ifdef DES_FRAME_STATS_EN
    ,
    output logic [STATS_W-1:0] good_frames,
    output logic [STATS_W-1:0] bad_frames
`endif
);

    localparam int IDX_W = $clog2(PAYLOAD_LEN);
    localparam int GW    = $clog2(LOCK_GOOD + 1);
    localparam int BW    = $clog2(LOSS_BAD + 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [7:0]       acc;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;
    logic             rx_bank;

    logic             wr_en;
    logic             good_evt;
    logic             bad_evt;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_inc;
    logic             keep_lock;

    assign wr_en    = in_valid && (state == ST_PAYLOAD);
    assign good_evt = in_valid && (state == ST_CHECK) && (in_data == acc);
    assign bad_evt  = in_valid &&
                      (((state == ST_CHECK) && (in_data != acc)) ||
                       ((state == ST_SYNC_WAIT) && (in_data != SYNC_BYTE)));

    // Run counters saturate at their thresholds; beyond that the value is irrelevant.
    assign good_inc  = (good_cnt == GW'(LOCK_GOOD)) ? good_cnt : good_cnt + 1'b1;
    assign bad_inc   = (bad_cnt == BW'(LOSS_BAD)) ? bad_cnt : bad_cnt + 1'b1;
    assign keep_lock = locked && (bad_inc < BW'(LOSS_BAD));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_HUNT;
            cnt       <= '0;
            acc       <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            rx_bank   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_HUNT, ST_SYNC_WAIT: begin
                    if (in_valid && (in_data == SYNC_BYTE)) begin
                        state <= ST_PAYLOAD;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid) begin
                        acc <= acc ^ in_data;
                        cnt <= cnt + 1'b1;
                        if (cnt == IDX_W'(PAYLOAD_LEN - 1))
                            state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (good_evt) begin
                        frame_ok <= 1'b1;
                        good_cnt <= good_inc;
                        bad_cnt  <= '0;
                        rx_bank  <= ~rx_bank;
                        state    <= ST_SYNC_WAIT;
                        if (good_inc == GW'(LOCK_GOOD))
                            locked <= 1'b1;
                    end
                end
                default: state <= ST_HUNT;
            endcase

            if (bad_evt) begin
                frame_err <= 1'b1;
                bad_cnt   <= bad_inc;
                good_cnt  <= '0;
                if (keep_lock) begin
                    state <= ST_SYNC_WAIT;
                end else begin
                    state  <= ST_HUNT;
                    locked <= 1'b0;
                end
            end
        end
    end

`ifdef DES_FRAME_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            good_frames <= '0;
            bad_frames  <= '0;
        end else begin
            if (good_evt)
                good_frames <= stat_inc(good_frames);
            if (bad_evt)
                bad_frames <= stat_inc(bad_frames);
        end
    end
`endif

    des_frame_buf #(
        .PAYLOAD_LEN(PAYLOAD_LEN)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_bank   (rx_bank),
        .wr_idx    (cnt),
        .wr_data   (in_data),
        .commit    (good_evt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

endmodule
